// File: rtl/mdu_sequencer.sv
// Multi-cycle mult/multu/div/divu sequencer writing the HI/LO pair after 32 iterations.
// Optional feature macro: MDU_DIV_EN enables the divide datapath (div/divu).
module mdu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  func,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        use_hilo,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic        op_sgn, op_div;
    logic        func_mul, func_dv, accept;
    logic        neg_res;
    logic [31:0] opa, opb, amag, bmag;
    logic [32:0] add33;
    logic [63:0] acc, acc_step, res;
`ifdef MDU_DIV_EN
    logic        neg_rem;
    logic [32:0] sub33;
`endif

    function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
        if (sgn && v < 0)
            return 32'(-v);
        return v;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    always_comb begin
        func_mul = (func == F_MULT) || (func == F_MULTU);
`ifdef MDU_DIV_EN
        func_dv  = (func == F_DIV) || (func == F_DIVU);
`else
        func_dv  = 1'b0;
`endif
        // flush in IDLE drops a coincident request
        accept   = start && !flush && (func_mul || func_dv);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = PREP;
            PREP:    state_nxt = flush ? IDLE : RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign stall = (use_hilo && state != IDLE && state != DONE) || (start && state != IDLE);

    assign amag = mag32(opa, op_sgn);
    assign bmag = mag32(opb, op_sgn);

    always_comb begin
        add33    = {1'b0, acc[63:32]} + {1'b0, opa};
        acc_step = acc[0] ? {add33, acc[31:1]} : {1'b0, acc[63:1]};
`ifdef MDU_DIV_EN
        // restoring step: shifted partial remainder minus divisor; borrow keeps the shift
        sub33 = acc[63:31] - {1'b0, opb};
        if (op_div)
            acc_step = sub33[32] ? {acc[62:0], 1'b0} : {sub33[31:0], acc[30:0], 1'b1};
`endif
    end

    always_comb begin
        res = neg64(acc, neg_res);
`ifdef MDU_DIV_EN
        // divide by zero shifts the dividend into the remainder half, so hi already equals a
        if (op_div) begin
            res[63:32] = neg32(acc[63:32], neg_rem);
            res[31:0]  = (opb == 32'd0) ? 32'hFFFF_FFFF : neg32(acc[31:0], neg_res);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            op_sgn <= 1'b0;
            op_div <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                op_sgn <= (func == F_MULT) || (func == F_DIV);
                op_div <= func_dv;
            end
            if (state == PREP)
                cnt <= 5'd0;
            else if (state == RUN)
                cnt <= cnt + 5'd1;
            if (state == FIX && !flush) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end
        end
    end

    // operand / accumulator datapath
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            opa <= a;
            opb <= b;
        end else if (state == PREP) begin
            opa     <= amag;
            opb     <= bmag;
            acc     <= {32'd0, op_div ? amag : bmag};
            neg_res <= op_sgn && (opa[31] ^ opb[31]);
`ifdef MDU_DIV_EN
            neg_rem <= op_sgn && opa[31];
`endif
        end else if (state == RUN) begin
            acc <= acc_step;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer against an arithmetic reference model.
// Divide expectations follow the MDU_DIV_EN macro of the build.
module tb_mdu_sequencer;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n, start, flush, use_hilo;
    logic [5:0]  func;
    logic [31:0] a, b;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .a(a), .b(b),
        .flush(flush), .use_hilo(use_hilo), .busy(busy), .done(done),
        .stall(stall), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit valid_f(input logic [5:0] f);
`ifdef MDU_DIV_EN
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
`else
        return (f == F_MULT) || (f == F_MULTU);
`endif
    endfunction

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        int sx, sy;
        sx = x;
        sy = y;
        case (f)
            F_MULT: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            F_MULTU: return {32'd0, x} * {32'd0, y};
            F_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            F_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [63:0] e;
        bit ok;
        int dseen;
        ok = valid_f(f);
        e  = ok ? model(f, x, y) : {mhi, mlo};
        @(negedge clk);
        start = 1'b1; func = f; a = x; b = y;
        #1 chk({tag, " stall_idle"}, 64'(stall), 64'(0));
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; func = 6'($urandom);
        chk({tag, " busy"}, 64'(busy), 64'(ok));
        dseen = 0;
        repeat (33) begin
            @(posedge clk); #1;
            dseen += int'(done);
        end
        chk({tag, " early_done"}, 64'(dseen), 64'(0));
        chk({tag, " hilo_hold"}, {hi, lo}, {mhi, mlo});
        @(posedge clk); #1;
        chk({tag, " done"}, 64'(done), 64'(ok));
        chk({tag, " hilo"}, {hi, lo}, e);
        @(posedge clk); #1;
        chk({tag, " done_end"}, 64'(done), 64'(0));
        chk({tag, " busy_end"}, 64'(busy), 64'(0));
        mhi = e[63:32];
        mlo = e[31:0];
    endtask

    initial begin
        logic [5:0]  fl [4];
        logic [31:0] x1, y1, x2, y2, rx, ry;
        logic [63:0] e1, e2;
        int dseen;
        fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; use_hilo = 1'b0;
        func = 6'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst stall", 64'(stall), 64'(0));
        chk("rst hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; use_hilo = 1'b1;
        #1 chk("idle use_hilo stall", 64'(stall), 64'(0));
        use_hilo = 1'b0;

        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(F_DIVU, 32'd100, 32'd7, "divu");
        run_op(F_DIV, 32'h1234, 32'd0, "div_zero");
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(6'b000000, 32'd5, 32'd6, "unknown");

        // held start with use_hilo: operands change after the first start edge
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        e1 = model(F_MULT, x1, y1);
        e2 = model(F_MULTU, x2, y2);
        @(negedge clk);
        use_hilo = 1'b1; start = 1'b1; func = F_MULT; a = x1; b = y1;
        @(posedge clk); #1;
        chk("hold busy", 64'(busy), 64'(1));
        func = F_MULTU; a = x2; b = y2;
        @(posedge clk); #1;
        chk("hold stall n1", 64'(stall), 64'(1));
        repeat (32) @(posedge clk);
        #1;
        chk("hold stall n33", 64'(stall), 64'(1));
        chk("hold done n33", 64'(done), 64'(0));
        @(posedge clk); #1;
        chk("hold done", 64'(done), 64'(1));
        chk("hold hilo1", {hi, lo}, e1);
        @(posedge clk); #1;
        chk("hold idle busy", 64'(busy), 64'(0));
        chk("hold idle stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        chk("hold second accept", 64'(busy), 64'(1));
        start = 1'b0; use_hilo = 1'b0; a = $urandom; b = $urandom;
        #1 chk("hold stall released", 64'(stall), 64'(0));
        repeat (33) @(posedge clk);
        #1;
        chk("hold hilo1 kept", {hi, lo}, e1);
        @(posedge clk); #1;
        chk("hold done2", 64'(done), 64'(1));
        chk("hold hilo2", {hi, lo}, e2);
        mhi = e2[63:32]; mlo = e2[31:0];
        @(posedge clk); #1;

        // flush mid-multiply
        @(negedge clk);
        start = 1'b1; func = F_MULT; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'(0));
        dseen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            dseen += int'(done);
        end
        chk("flush no_done", 64'(dseen), 64'(0));
        chk("flush hilo", {hi, lo}, {mhi, mlo});
        @(negedge clk);
        start = 1'b1; flush = 1'b1; func = F_MULTU;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start busy", 64'(busy), 64'(0));

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; func = F_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("areset busy", 64'(busy), 64'(0));
        chk("areset done", 64'(done), 64'(0));
        chk("areset hilo", {hi, lo}, 64'd0);
        mhi = 32'd0; mlo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(F_MULT, 32'h0001_0003, 32'hFFFF_0005, "post_reset");

        for (int i = 0; i < 12; i++) begin
            rx = $urandom;
            ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) ry = ry & 32'h0000_00FF;
            run_op(fl[$urandom_range(0, 3)], rx, ry, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
